// File: rtl/slot_scorer_pkg.sv
// Shared constants and types for the slot machine scorer: seven-segment
// encodings (active-low, gfedcba), score limits and payout table.
package slot_scorer_pkg;

  localparam int SCORE_W = 14;

  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;
  localparam logic [6:0] BLANK = 7'b1111111;

  localparam logic [SCORE_W-1:0] START_SCORE = 14'd100;
  localparam logic [SCORE_W-1:0] SPIN_COST   = 14'd10;
  localparam logic [SCORE_W-1:0] MAX_SCORE   = 14'd9999;

  localparam logic [SCORE_W-1:0] PAYOUT_FOUR     = 14'd500;
  localparam logic [SCORE_W-1:0] PAYOUT_THREE    = 14'd100;
  localparam logic [SCORE_W-1:0] PAYOUT_TWO_PAIR = 14'd50;
  localparam logic [SCORE_W-1:0] PAYOUT_PAIR     = 14'd20;

  typedef enum logic [2:0] {
    HAND_NONE,
    HAND_PAIR,
    HAND_TWO_PAIR,
    HAND_THREE,
    HAND_FOUR
  } hand_e;

  function automatic logic [SCORE_W-1:0] payout_of(input hand_e hand);
    case (hand)
      HAND_FOUR:     return PAYOUT_FOUR;
      HAND_THREE:    return PAYOUT_THREE;
      HAND_TWO_PAIR: return PAYOUT_TWO_PAIR;
      HAND_PAIR:     return PAYOUT_PAIR;
      default:       return '0;
    endcase
  endfunction

endpackage

// File: rtl/slot_scorer_seg_encoder.sv
// Combinational 4-bit digit to active-low seven-segment pattern (gfedcba).
// Codes above 9 blank the display.
module seg_encoder
  import slot_scorer_pkg::*;
(
  input  logic [3:0] digit_i,
  output logic [6:0] seg_o
);

  always_comb begin
    case (digit_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = BLANK;
    endcase
  end

endmodule

// File: rtl/slot_scorer.sv
// Slot machine scorer: freezes four reel displays, scores the frozen pattern
// on a rising score request and keeps a saturating credit balance with BCD out.
module slot_scorer
  import slot_scorer_pkg::*;
(
  input  logic               clk,
  input  logic               btnR_n,
  input  logic [3:0]         num1,
  input  logic [3:0]         num2,
  input  logic [3:0]         num3,
  input  logic [3:0]         num4,
  input  logic               stop1,
  input  logic               stop2,
  input  logic               stop3,
  input  logic               stop4,
  input  logic               to_score,
  output logic [6:0]         seg1,
  output logic [6:0]         seg2,
  output logic [6:0]         seg3,
  output logic [6:0]         seg4,
  output logic [SCORE_W-1:0] score,
  output logic [3:0]         score1,
  output logic [3:0]         score2,
  output logic [3:0]         score3,
  output logic [3:0]         score4,
  output logic               is_broke
);

  logic [3:0]         num_w [4];
  logic [3:0]         stop_w;
  logic [6:0]         enc_w [4];
  logic [6:0]         seg_q [4];
  logic               to_score_q;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [2:0]         pair_cnt;
  hand_e              hand;
  logic               score_event;
  logic [SCORE_W:0]   sum;
  logic [15:0]        bcd;

  assign num_w[0] = num1;
  assign num_w[1] = num2;
  assign num_w[2] = num3;
  assign num_w[3] = num4;
  assign stop_w   = {stop4, stop3, stop2, stop1};

  for (genvar g = 0; g < 4; g++) begin : g_enc
    seg_encoder u_seg_encoder (
      .digit_i (num_w[g]),
      .seg_o   (enc_w[g])
    );
  end

  // NOTE: the reel registers form a tiny array, so every entry is reset
  // explicitly; a real RAM would not get this and would need a valid flag.
  always_ff @(posedge clk or negedge btnR_n) begin
    if (!btnR_n) begin
      for (int i = 0; i < 4; i++) seg_q[i] <= SEG_0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (!stop_w[i]) seg_q[i] <= enc_w[i];
      end
    end
  end

  // Counting equal pairs among the six reel combinations classifies the hand:
  // 6 = four of a kind, 3 = three, 2 = two pair, 1 = one pair.
  always_comb begin
    pair_cnt = '0;
    for (int i = 0; i < 3; i++) begin
      for (int j = i + 1; j < 4; j++) begin
        if (seg_q[i] == seg_q[j] && seg_q[i] != BLANK) pair_cnt = pair_cnt + 3'd1;
      end
    end
    case (pair_cnt)
      3'd6:    hand = HAND_FOUR;
      3'd3:    hand = HAND_THREE;
      3'd2:    hand = HAND_TWO_PAIR;
      3'd1:    hand = HAND_PAIR;
      default: hand = HAND_NONE;
    endcase
  end

  assign score_event = to_score && !to_score_q && (&stop_w);
  assign sum = {1'b0, score_q} - {1'b0, SPIN_COST} + {1'b0, payout_of(hand)};

  // NOTE: combinational blocks assign a default first so no path leaves
  // score_d unassigned, which would otherwise infer a latch.
  always_comb begin
    score_d = score_q;
    if (score_event && score_q >= SPIN_COST) begin
      score_d = (sum > {1'b0, MAX_SCORE}) ? MAX_SCORE : sum[SCORE_W-1:0];
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge btnR_n) begin
    if (!btnR_n) begin
      score_q    <= START_SCORE;
      to_score_q <= 1'b0;
    end else begin
      score_q    <= score_d;
      to_score_q <= to_score;
    end
  end

  // Shift-and-add-3 binary to BCD, MSB first.
  always_comb begin
    bcd = '0;
    for (int b = SCORE_W - 1; b >= 0; b--) begin
      for (int d = 0; d < 4; d++) begin
        if (bcd[4*d +: 4] >= 4'd5) bcd[4*d +: 4] = bcd[4*d +: 4] + 4'd3;
      end
      bcd = {bcd[14:0], score_q[b]};
    end
  end

  assign seg1     = seg_q[0];
  assign seg2     = seg_q[1];
  assign seg3     = seg_q[2];
  assign seg4     = seg_q[3];
  assign score    = score_q;
  assign score1   = bcd[15:12];
  assign score2   = bcd[11:8];
  assign score3   = bcd[7:4];
  assign score4   = bcd[3:0];
  assign is_broke = (score_q < SPIN_COST);

endmodule

// File: tb/tb_slot_scorer.sv
// Self-checking bench for slot_scorer: directed scenarios plus randomized
// play, all checked against a histogram-based reference model.
module tb_slot_scorer;

  logic        clk = 1'b0;
  logic        btnR_n = 1'b0;
  logic [3:0]  num_a [4];
  logic        stop_a [4];
  logic        to_score = 1'b0;
  logic [6:0]  seg1, seg2, seg3, seg4;
  logic [13:0] score;
  logic [3:0]  score1, score2, score3, score4;
  logic        is_broke;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: displayed digit per reel (>9 means blank).
  int m_val [4];
  int m_score;
  bit m_prev;

  localparam logic [6:0] SEG_TAB [10] = '{7'b1000000, 7'b1111001, 7'b0100100,
    7'b0110000, 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000,
    7'b0010000};

  always #5 clk = ~clk;

  slot_scorer dut (
    .clk      (clk),
    .btnR_n   (btnR_n),
    .num1     (num_a[0]),
    .num2     (num_a[1]),
    .num3     (num_a[2]),
    .num4     (num_a[3]),
    .stop1    (stop_a[0]),
    .stop2    (stop_a[1]),
    .stop3    (stop_a[2]),
    .stop4    (stop_a[3]),
    .to_score (to_score),
    .seg1     (seg1),
    .seg2     (seg2),
    .seg3     (seg3),
    .seg4     (seg4),
    .score    (score),
    .score1   (score1),
    .score2   (score2),
    .score3   (score3),
    .score4   (score4),
    .is_broke (is_broke)
  );

  function automatic int model_payout();
    int cnt [10];
    int mx, pairs;
    foreach (cnt[k]) cnt[k] = 0;
    for (int i = 0; i < 4; i++) if (m_val[i] <= 9) cnt[m_val[i]]++;
    mx = 0; pairs = 0;
    foreach (cnt[k]) begin
      if (cnt[k] > mx) mx = cnt[k];
      if (cnt[k] == 2) pairs++;
    end
    if (mx == 4) return 500;
    if (mx == 3) return 100;
    if (pairs == 2) return 50;
    if (pairs == 1) return 20;
    return 0;
  endfunction

  function automatic logic [6:0] model_seg(int v);
    return (v <= 9) ? SEG_TAB[v] : 7'b1111111;
  endfunction

  function automatic logic [15:0] model_bcd(int v);
    return {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // Advance model by one clock using the inputs as currently driven.
  task automatic tick();
    bit all_stop;
    all_stop = stop_a[0] && stop_a[1] && stop_a[2] && stop_a[3];
    if (to_score && !m_prev && all_stop && m_score >= 10) begin
      m_score = m_score - 10 + model_payout();
      if (m_score > 9999) m_score = 9999;
    end
    for (int i = 0; i < 4; i++) if (!stop_a[i]) m_val[i] = int'(num_a[i]);
    m_prev = to_score;
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_score = 100;
    m_prev  = 1'b0;
    for (int i = 0; i < 4; i++) m_val[i] = 0;
  endtask

  task automatic apply_reset();
    btnR_n   = 1'b0;
    to_score = 1'b0;
    for (int i = 0; i < 4; i++) begin
      num_a[i]  = 4'd0;
      stop_a[i] = 1'b0;
    end
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    btnR_n = 1'b1;
  endtask

  task automatic set_stops(bit s);
    for (int i = 0; i < 4; i++) stop_a[i] = s;
  endtask

  // Load reels, freeze them, then pulse to_score `pulses` times.
  task automatic spin(int n1, int n2, int n3, int n4, int pulses);
    num_a[0] = 4'(n1); num_a[1] = 4'(n2); num_a[2] = 4'(n3); num_a[3] = 4'(n4);
    set_stops(1'b0);
    tick();
    set_stops(1'b1);
    tick();
    for (int p = 0; p < pulses; p++) begin
      to_score = 1'b1; tick();
      to_score = 1'b0; tick();
    end
  endtask

  task automatic test_reset();
    btnR_n = 1'b0;
    num_a[0] = 4'd5; num_a[1] = 4'd6; num_a[2] = 4'd7; num_a[3] = 4'd8;
    set_stops(1'b0);
    to_score = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({score, score1, score2, score3, score4, is_broke} !== {14'd100, 4'd0, 4'd1, 4'd0, 4'd0, 1'b0}) begin
      n_errors++;
      $display("FAIL reset_score: got score=%0d digits=%0d%0d%0d%0d broke=%b, want 100 0100 0",
               score, score1, score2, score3, score4, is_broke);
    end
    n_checks++;
    if ({seg1, seg2, seg3, seg4} !== {4{7'b1000000}}) begin
      n_errors++;
      $display("FAIL reset_segs: got %b %b %b %b, want 1000000 x4", seg1, seg2, seg3, seg4);
    end
    apply_reset();
  endtask

  task automatic test_payouts();
    int nums [4][4] = '{'{7, 7, 7, 7}, '{3, 3, 3, 5}, '{1, 1, 2, 2}, '{4, 4, 6, 8}};
    int want [4] = '{590, 190, 140, 110};
    for (int t = 0; t < 4; t++) begin
      apply_reset();
      spin(nums[t][0], nums[t][1], nums[t][2], nums[t][3], 1);
      n_checks++;
      if (score !== 14'(want[t])) begin
        n_errors++;
        $display("FAIL payout_%0d: got score=%0d, want %0d", t, score, want[t]);
      end
    end
    n_checks++;
    if ({score1, score2, score3, score4} !== 16'h0110) begin
      n_errors++;
      $display("FAIL payout_bcd: got %h, want 0110", {score1, score2, score3, score4});
    end
    apply_reset();
    spin(7, 7, 7, 7, 1);
    n_checks++;
    if ({score1, score2, score3, score4} !== 16'h0590) begin
      n_errors++;
      $display("FAIL bcd_590: got %h, want 0590", {score1, score2, score3, score4});
    end
  endtask

  task automatic test_broke();
    apply_reset();
    spin(1, 2, 3, 4, 10);
    n_checks++;
    if (score !== 14'd0 || is_broke !== 1'b1) begin
      n_errors++;
      $display("FAIL broke: got score=%0d broke=%b, want 0 1", score, is_broke);
    end
    to_score = 1'b1; tick();
    to_score = 1'b0; tick();
    n_checks++;
    if (score !== 14'd0) begin
      n_errors++;
      $display("FAIL broke_ignore: got score=%0d, want 0", score);
    end
  endtask

  task automatic test_hold();
    apply_reset();
    spin(1, 2, 3, 4, 0);
    to_score = 1'b1;
    repeat (5) tick();
    to_score = 1'b0;
    tick();
    n_checks++;
    if (score !== 14'd90) begin
      n_errors++;
      $display("FAIL hold_one_event: got score=%0d, want 90", score);
    end
  endtask

  task automatic test_stop_low();
    apply_reset();
    spin(7, 7, 7, 7, 0);
    stop_a[1] = 1'b0;
    to_score = 1'b1; tick();
    to_score = 1'b0; tick();
    n_checks++;
    if (score !== 14'd100) begin
      n_errors++;
      $display("FAIL stop2_low: got score=%0d, want 100", score);
    end
  endtask

  task automatic test_blank();
    apply_reset();
    spin(12, 12, 12, 12, 1);
    n_checks++;
    if (seg1 !== 7'b1111111) begin
      n_errors++;
      $display("FAIL blank_seg1: got %b, want 1111111", seg1);
    end
    n_checks++;
    if (score !== 14'd90) begin
      n_errors++;
      $display("FAIL blank_no_match: got score=%0d, want 90", score);
    end
  endtask

  task automatic test_saturate();
    apply_reset();
    spin(8, 8, 8, 8, 20);
    n_checks++;
    if (score !== 14'd9900) begin
      n_errors++;
      $display("FAIL near_max: got score=%0d, want 9900", score);
    end
    to_score = 1'b1; tick();
    to_score = 1'b0; tick();
    n_checks++;
    if (score !== 14'd9999 || {score1, score2, score3, score4} !== 16'h9999) begin
      n_errors++;
      $display("FAIL saturate: got score=%0d digits=%h, want 9999", score, {score1, score2, score3, score4});
    end
  endtask

  task automatic test_mid_reset();
    apply_reset();
    spin(7, 7, 7, 7, 1);
    to_score = 1'b1;
    #2;
    btnR_n = 1'b0;
    #1;
    n_checks++;
    if (score !== 14'd100 || {seg1, seg2, seg3, seg4} !== {4{7'b1000000}}) begin
      n_errors++;
      $display("FAIL mid_reset: got score=%0d seg1=%b, want 100 1000000", score, seg1);
    end
    apply_reset();
  endtask

  task automatic test_random();
    logic [6:0]  exp_seg [4];
    logic [15:0] exp_bcd;
    apply_reset();
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < 4; i++) begin
        num_a[i]  = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 3));
        stop_a[i] = ($urandom_range(0, 4) != 0);
      end
      to_score = $urandom_range(0, 1) == 1;
      tick();
      for (int i = 0; i < 4; i++) exp_seg[i] = model_seg(m_val[i]);
      exp_bcd = model_bcd(m_score);
      n_checks++;
      if (score !== 14'(m_score) || is_broke !== (m_score < 10)) begin
        n_errors++;
        $display("FAIL rand_score c=%0d: got %0d broke=%b, want %0d", c, score, is_broke, m_score);
      end
      n_checks++;
      if ({seg1, seg2, seg3, seg4} !== {exp_seg[0], exp_seg[1], exp_seg[2], exp_seg[3]}) begin
        n_errors++;
        $display("FAIL rand_seg c=%0d: got %b %b %b %b, want %b %b %b %b", c, seg1, seg2, seg3, seg4,
                 exp_seg[0], exp_seg[1], exp_seg[2], exp_seg[3]);
      end
      n_checks++;
      if ({score1, score2, score3, score4} !== exp_bcd) begin
        n_errors++;
        $display("FAIL rand_bcd c=%0d: got %h, want %h", c, {score1, score2, score3, score4}, exp_bcd);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      num_a[i]  = 4'd0;
      stop_a[i] = 1'b0;
    end
    model_reset();
    test_reset();
    test_payouts();
    test_broke();
    test_hold();
    test_stop_low();
    test_blank();
    test_saturate();
    test_mid_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
